// File: rtl/arp_send.sv
// ARP frame builder: answers requests addressed to us, records resolved peers,
// and emits locally triggered requests as a 32-bit word stream with handshake.
module arp_send #(
    parameter int FRAME_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic [31:0] i_self_ip,
    input  logic [1:0]  i_arp_operation,
    input  logic [47:0] i_arp_target_mac,
    input  logic [31:0] i_arp_target_ip,
    input  logic        i_req,
    input  logic [31:0] i_req_ip,
    output logic [31:0] o_data,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_sop,
    output logic        o_eop,
    output logic        o_busy,
    output logic [47:0] o_peer_mac,
    output logic [31:0] o_peer_ip,
    output logic        o_peer_vld,
    output logic [7:0]  o_drop_cnt
);

    localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [WW-1:0] LAST_W = WW'(FRAME_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_r;
    logic [WW-1:0] w_r;
    logic [WW-1:0] nxt_w_s;

    logic          reply_pend_r;
    logic          req_pend_r;
    logic [47:0]   reply_mac_r;
    logic [31:0]   reply_ip_r;
    logic [31:0]   req_ip_r;

    logic          start_s;
    logic          take_reply_s;
    logic          take_req_s;
    logic [47:0]   da_s;
    logic [47:0]   tha_s;
    logic [15:0]   op_s;
    logic [31:0]   tpa_s;

    logic [47:0]   da_r;
    logic [47:0]   sa_r;
    logic [47:0]   tha_r;
    logic [15:0]   op_r;
    logic [31:0]   spa_r;
    logic [31:0]   tpa_r;

    // SA doubles as SHA: an ARP sender always advertises its own MAC.
    function automatic logic [31:0] frame_word(
        input logic [6:0]  idx,
        input logic [47:0] da,
        input logic [47:0] sa,
        input logic [15:0] op,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        logic [31:0] word;
        case (idx)
            7'd0:    word = {16'h0000, da[47:32]};
            7'd1:    word = da[31:0];
            7'd2:    word = sa[47:16];
            7'd3:    word = {sa[15:0], 16'h0806};
            7'd4:    word = {16'h0001, 16'h0800};
            7'd5:    word = {8'h06, 8'h04, op};
            7'd6:    word = sa[47:16];
            7'd7:    word = {sa[15:0], spa[31:16]};
            7'd8:    word = {spa[15:0], tha[47:32]};
            7'd9:    word = tha[31:0];
            7'd10:   word = tpa;
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Frame selection at IDLE exit: reply wins over request.
    always_comb begin
        start_s      = (state_r == IDLE) && (reply_pend_r || req_pend_r);
        take_reply_s = start_s && reply_pend_r;
        take_req_s   = start_s && !reply_pend_r;
        nxt_w_s      = w_r + WW'(1);
        if (reply_pend_r) begin
            da_s  = reply_mac_r;
            op_s  = 16'h0002;
            tha_s = reply_mac_r;
            tpa_s = reply_ip_r;
        end else begin
            da_s  = 48'hFFFF_FFFF_FFFF;
            op_s  = 16'h0001;
            tha_s = 48'h0000_0000_0000;
            tpa_s = req_ip_r;
        end
    end

    // One-deep trigger latches and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reply_pend_r <= 1'b0;
            reply_mac_r  <= 48'h0;
            reply_ip_r   <= 32'h0;
            req_pend_r   <= 1'b0;
            req_ip_r     <= 32'h0;
            o_drop_cnt   <= 8'h00;
        end else begin
            if (i_arp_operation == 2'd1) begin
                if (reply_pend_r && !take_reply_s) begin
                    if (o_drop_cnt != 8'hFF) begin
                        o_drop_cnt <= o_drop_cnt + 8'd1;
                    end else begin
                        o_drop_cnt <= o_drop_cnt;
                    end
                end else begin
                    reply_pend_r <= 1'b1;
                    reply_mac_r  <= i_arp_target_mac;
                    reply_ip_r   <= i_arp_target_ip;
                end
            end else if (take_reply_s) begin
                reply_pend_r <= 1'b0;
            end else begin
                reply_pend_r <= reply_pend_r;
            end

            if (i_req) begin
                req_pend_r <= 1'b1;
                req_ip_r   <= i_req_ip;
            end else if (take_req_s) begin
                req_pend_r <= 1'b0;
            end else begin
                req_pend_r <= req_pend_r;
            end
        end
    end

    // Resolved peer, updated from incoming replies regardless of FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_peer_mac <= 48'h0;
            o_peer_ip  <= 32'h0;
            o_peer_vld <= 1'b0;
        end else if (i_arp_operation == 2'd2) begin
            o_peer_mac <= i_arp_target_mac;
            o_peer_ip  <= i_arp_target_ip;
            o_peer_vld <= 1'b1;
        end else begin
            o_peer_vld <= o_peer_vld;
        end
    end

    // Frame FSM; word 0 is computed from live fields because the snapshot
    // registers only load on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            w_r     <= '0;
            o_data  <= 32'h0;
            o_vld   <= 1'b0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
            o_busy  <= 1'b0;
            da_r    <= 48'h0;
            sa_r    <= 48'h0;
            tha_r   <= 48'h0;
            op_r    <= 16'h0;
            spa_r   <= 32'h0;
            tpa_r   <= 32'h0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_r <= SEND;
                        w_r     <= '0;
                        da_r    <= da_s;
                        sa_r    <= i_self_mac;
                        tha_r   <= tha_s;
                        op_r    <= op_s;
                        spa_r   <= i_self_ip;
                        tpa_r   <= tpa_s;
                        o_data  <= frame_word(7'd0, da_s, i_self_mac, op_s,
                                              i_self_ip, tha_s, tpa_s);
                        o_vld   <= 1'b1;
                        o_sop   <= 1'b1;
                        o_eop   <= 1'b0;
                        o_busy  <= 1'b1;
                    end else begin
                        o_vld   <= 1'b0;
                        o_sop   <= 1'b0;
                        o_eop   <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                SEND: begin
                    if (o_vld && i_rdy) begin
                        if (w_r == LAST_W) begin
                            state_r <= IDLE;
                            o_data  <= 32'h0;
                            o_vld   <= 1'b0;
                            o_sop   <= 1'b0;
                            o_eop   <= 1'b0;
                            o_busy  <= 1'b0;
                        end else begin
                            w_r     <= nxt_w_s;
                            o_data  <= frame_word(7'(nxt_w_s), da_r, sa_r, op_r,
                                                  spa_r, tha_r, tpa_r);
                            o_sop   <= 1'b0;
                            o_eop   <= (nxt_w_s == LAST_W);
                        end
                    end else begin
                        o_vld   <= o_vld;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    o_vld   <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_send.sv
// Scoreboard bench for arp_send: stimulus pushes expected words, a monitor
// pops and compares on every accepted output word.
module tb_arp_send;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] i_self_mac;
    logic [31:0] i_self_ip;
    logic [1:0]  i_arp_operation;
    logic [47:0] i_arp_target_mac;
    logic [31:0] i_arp_target_ip;
    logic        i_req;
    logic [31:0] i_req_ip;
    logic [31:0] o_data;
    logic        o_vld;
    logic        i_rdy;
    logic        o_sop;
    logic        o_eop;
    logic        o_busy;
    logic [47:0] o_peer_mac;
    logic [31:0] o_peer_ip;
    logic        o_peer_vld;
    logic [7:0]  o_drop_cnt;

    always #5 clk = ~clk;

    arp_send #(.FRAME_WORDS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
        .i_arp_operation(i_arp_operation),
        .i_arp_target_mac(i_arp_target_mac), .i_arp_target_ip(i_arp_target_ip),
        .i_req(i_req), .i_req_ip(i_req_ip),
        .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy),
        .o_sop(o_sop), .o_eop(o_eop), .o_busy(o_busy),
        .o_peer_mac(o_peer_mac), .o_peer_ip(o_peer_ip), .o_peer_vld(o_peer_vld),
        .o_drop_cnt(o_drop_cnt)
    );

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   popped_cnt = 0;
    int   cyc = 0;
    logic gap_armed = 1'b0;
    logic gap_pending = 1'b0;
    int   last_eop_cyc = 0;
    logic stall_seen = 1'b0;
    logic [31:0] prev_data;
    logic prev_sop, prev_eop;

    // Hand-derived header words 0..10; words 11..15 are zero.
    localparam logic [0:10][31:0] REPLY1 = {
        32'h0000_02AA, 32'hBBCC_DDEE, 32'h0200_0000, 32'h0001_0806,
        32'h0001_0800, 32'h0604_0002, 32'h0200_0000, 32'h0001_0A00,
        32'h0001_02AA, 32'hBBCC_DDEE, 32'h0A00_0007};
    localparam logic [0:10][31:0] REQ1 = {
        32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0200_0000, 32'h0001_0806,
        32'h0001_0800, 32'h0604_0001, 32'h0200_0000, 32'h0001_0A00,
        32'h0001_0000, 32'h0000_0000, 32'h0A00_0009};
    localparam logic [0:10][31:0] REPLYB = {
        32'h0000_0211, 32'h1111_1111, 32'h0200_0000, 32'h0001_0806,
        32'h0001_0800, 32'h0604_0002, 32'h0200_0000, 32'h0001_0A00,
        32'h0001_0211, 32'h1111_1111, 32'h0A00_0003};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [0:10][31:0] h);
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            e.sop  = (i == 0);
            e.eop  = (i == 15);
            e.data = 32'h0;
            if (i < 11) e.data = h[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic op_pulse(input logic [1:0] op, input logic [47:0] mac, input logic [31:0] ip);
        @(posedge clk); #1;
        i_arp_operation  = op;
        i_arp_target_mac = mac;
        i_arp_target_ip  = ip;
        @(posedge clk); #1;
        i_arp_operation  = 2'd0;
    endtask

    task automatic req_pulse(input logic [31:0] ip);
        @(posedge clk); #1;
        i_req    = 1'b1;
        i_req_ip = ip;
        @(posedge clk); #1;
        i_req    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while ((exp_q.size() != 0 || o_busy) && g < 500) begin
            @(posedge clk);
            g++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops on each handshake and checks hold during stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_seen) begin
                chk("hold_data", 64'(o_data), 64'(prev_data));
                chk("hold_ctl", {61'd0, o_vld, o_sop, o_eop}, {61'd0, 1'b1, prev_sop, prev_eop});
            end
            if (o_vld && i_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", o_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word", {30'd0, o_sop, o_eop, o_data}, {30'd0, e.sop, e.eop, e.data});
                    popped_cnt++;
                    if (o_sop && gap_pending) begin
                        chk("idle_gap", 64'(cyc - last_eop_cyc), 64'd2);
                        gap_pending = 1'b0;
                    end
                    if (o_eop) begin
                        last_eop_cyc = cyc;
                        gap_pending  = gap_armed;
                    end
                end
            end
            stall_seen = o_vld && !i_rdy;
            prev_data  = o_data;
            prev_sop   = o_sop;
            prev_eop   = o_eop;
        end else begin
            stall_seen = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int g;
        rst_n            = 1'b0;
        i_self_mac       = 48'h0200_0000_0001;
        i_self_ip        = 32'h0A00_0001;
        i_arp_operation  = 2'd0;
        i_arp_target_mac = 48'h0;
        i_arp_target_ip  = 32'h0;
        i_req            = 1'b0;
        i_req_ip         = 32'h0;
        i_rdy            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {59'd0, o_vld, o_sop, o_eop, o_busy, o_peer_vld}, 64'd0);
        chk("rst_data", 64'(o_data), 64'd0);
        chk("rst_peer", {o_peer_mac, 16'd0}, 64'd0);
        chk("rst_peer_ip", 64'(o_peer_ip), 64'd0);
        chk("rst_drop", 64'(o_drop_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reply from peer: recorded, no frame.
        op_pulse(2'd2, 48'h0211_2233_4455, 32'h0A00_0002);
        @(negedge clk);
        chk("peer_mac", 64'(o_peer_mac), 64'h0000_0211_2233_4455);
        chk("peer_ip", 64'(o_peer_ip), 64'h0A00_0002);
        chk("peer_vld", 64'(o_peer_vld), 64'd1);
        repeat (3) @(negedge clk);
        chk("peer_busy", {62'd0, o_busy, o_vld}, 64'd0);

        // Request to us answered with a reply; check latency.
        push_frame(REPLY1);
        op_pulse(2'd1, 48'h02AA_BBCC_DDEE, 32'h0A00_0007);
        @(negedge clk);
        chk("lat_n1", {62'd0, o_vld, o_busy}, 64'd0);
        @(negedge clk);
        chk("lat_n2", {62'd0, o_vld, o_sop}, 64'd3);
        wait_drain("reply_drain");

        // Local request.
        push_frame(REQ1);
        req_pulse(32'h0A00_0009);
        wait_drain("req_drain");

        // Same request with random throttling.
        push_frame(REQ1);
        req_pulse(32'h0A00_0009);
        g = 0;
        while ((exp_q.size() != 0 || o_busy) && g < 400) begin
            @(posedge clk); #1;
            i_rdy = 1'($urandom_range(0, 1));
            g++;
        end
        i_rdy = 1'b1;
        wait_drain("throttle_drain");

        // Simultaneous reply and request: reply first, one idle cycle between.
        gap_armed = 1'b1;
        push_frame(REPLY1);
        push_frame(REQ1);
        @(posedge clk); #1;
        i_arp_operation  = 2'd1;
        i_arp_target_mac = 48'h02AA_BBCC_DDEE;
        i_arp_target_ip  = 32'h0A00_0007;
        i_req            = 1'b1;
        i_req_ip         = 32'h0A00_0009;
        @(posedge clk); #1;
        i_arp_operation  = 2'd0;
        i_req            = 1'b0;
        wait_drain("simul_drain");
        gap_armed   = 1'b0;
        gap_pending = 1'b0;

        // Three triggers during one frame: second is sent, third dropped.
        push_frame(REPLY1);
        push_frame(REPLYB);
        op_pulse(2'd1, 48'h02AA_BBCC_DDEE, 32'h0A00_0007);
        repeat (4) @(posedge clk);
        op_pulse(2'd1, 48'h0211_1111_1111, 32'h0A00_0003);
        repeat (3) @(posedge clk);
        op_pulse(2'd1, 48'h0222_2222_2222, 32'h0A00_0004);
        wait_drain("drop_drain");
        chk("drop_cnt", 64'(o_drop_cnt), 64'd1);

        // Reset while word 6 is on the bus.
        push_frame(REQ1);
        base = popped_cnt;
        req_pulse(32'h0A00_0009);
        g = 0;
        while (popped_cnt - base < 6 && g < 100) begin
            @(posedge clk);
            g++;
        end
        chk("reach_w6", 64'(popped_cnt - base), 64'd6);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_ctl", {61'd0, o_vld, o_busy, o_eop}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_state", {55'd0, o_drop_cnt, o_peer_vld}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {62'd0, o_vld, o_busy}, 64'd0);
        push_frame(REQ1);
        req_pulse(32'h0A00_0009);
        wait_drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
